// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch handling,
// multi-cycle mul/div occupancy of Execute, dmem wait states and a stall-cycle counter.
//
// state | meaning
// IDLE  | no mul/div op occupying Execute
// BUSY  | mul/div op in Execute; cnt counts down remaining held cycles
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             LoadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MemReqM,
    input  logic             DmemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MdDoneE,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int CW = $clog2(MD_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CNT_W-1:0] stall_cnt;

    logic mem_stall;
    logic lw_stall;
    logic md_stall;
    logic cnt_zero;

    assign cnt_zero  = (cnt == '0);
    assign mem_stall = MemReqM & ~DmemReadyM;
    assign lw_stall  = LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign md_stall  = ((state == IDLE) & MdStartE) | ((state == BUSY) & ~cnt_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (StallF && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // A dmem wait state freezes the mul/div sequencer entirely.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!mem_stall) begin
            case (state)
                IDLE: begin
                    if (MdStartE) begin
                        state_nx = BUSY;
                        cnt_nx   = CW'(MD_LAT - 2);
                    end
                end
                BUSY: begin
                    if (!cnt_zero) cnt_nx = cnt - CW'(1);
                    else           state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        FlushW  = 1'b0;
        MdDoneE = 1'b0;
        MdBusy  = 1'b0;
        if (!reset) begin
            MdBusy  = (state == BUSY);
            MdDoneE = (state == BUSY) & cnt_zero & ~mem_stall;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (md_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Memory-stage result is younger than Writeback, so it wins on equal Rd.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end

    assign StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table for forwarding/priority, directed multi-cycle
// sequences, and randomized cycles against an occupancy-count reference model.
module tb_hazard_ctrl;

    localparam int MDL    = 4;
    localparam int CW     = 4;
    localparam int SC_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic LoadE, RegWriteM, RegWriteW, PCSrcE, MdStartE, MemReqM, DmemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic MdDoneE, MdBusy;
    logic [CW-1:0] StallCycles;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MD_LAT(MDL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MemReqM(MemReqM), .DmemReadyM(DmemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .MdDoneE(MdDoneE), .MdBusy(MdBusy), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       loade, regwm, regww, pcsrc, memreq, ready;
        logic [1:0] fa, fb;
        logic [3:0] stall;   // {F,D,E,M}
        logic [3:0] flush;   // {D,E,M,W}
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input logic [3:0] st, input logic [3:0] fl,
                           input logic done, input logic busy);
        chk({nm, ".stall"}, {28'd0, StallF, StallD, StallE, StallM}, {28'd0, st});
        chk({nm, ".flush"}, {28'd0, FlushD, FlushE, FlushM, FlushW}, {28'd0, fl});
        chk({nm, ".done"}, {31'd0, MdDoneE}, {31'd0, done});
        chk({nm, ".busy"}, {31'd0, MdBusy}, {31'd0, busy});
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MdStartE = 0;
        MemReqM = 0; DmemReadyM = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] x);
        if (RegWriteM && RdM != 0 && RdM == x) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == x) return 2'b01;
        return 2'b00;
    endfunction

    // reference model state: op in flight and non-frozen cycles it has spent in E
    int md_on, md_el, exp_sc;

    initial begin
        reset = 1'b1;
        clear_inputs();
        MdStartE = 1'b1;
        MemReqM  = 1'b1;
        #1;
        chk_ctl("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("reset_sc", {28'd0, StallCycles}, 32'd0);
        @(negedge clk);
        do_reset();

        //          rs1d rs2d rs1e rs2e rde rdm rdw ld wm ww pc mr rdy fa     fb     stall    flush
        tbl[0] = '{0, 0, 7, 0, 0, 7, 7, 0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 4'b0000, 4'b0000};
        tbl[1] = '{0, 0, 7, 7, 0, 0, 7, 0, 1, 1, 0, 0, 0, 2'b01, 2'b01, 4'b0000, 4'b0000};
        tbl[2] = '{0, 0, 7, 3, 0, 7, 7, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 4'b0000};
        tbl[3] = '{0, 0, 3, 3, 0, 3, 3, 0, 1, 0, 0, 0, 0, 2'b10, 2'b10, 4'b0000, 4'b0000};
        tbl[4] = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 4'b0100};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 4'b0000};
        tbl[6] = '{0, 9, 0, 0, 9, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 4'b1100};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 4'b1111, 4'b0001};
        tbl[8] = '{0, 4, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b1100, 4'b0100};
        tbl[9] = '{4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b1111, 4'b0001};

        for (int i = 0; i < 10; i++) begin
            Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
            RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
            LoadE = tbl[i].loade; RegWriteM = tbl[i].regwm; RegWriteW = tbl[i].regww;
            PCSrcE = tbl[i].pcsrc; MemReqM = tbl[i].memreq; DmemReadyM = tbl[i].ready;
            #1;
            chk($sformatf("vec%0d.fa", i), {30'd0, ForwardAE}, {30'd0, tbl[i].fa});
            chk($sformatf("vec%0d.fb", i), {30'd0, ForwardBE}, {30'd0, tbl[i].fb});
            chk_ctl($sformatf("vec%0d", i), tbl[i].stall, tbl[i].flush, 1'b0, 1'b0);
        end

        // load-use: one bubble, counted once
        do_reset();
        LoadE = 1; RdE = 5; Rs1D = 5;
        #1 chk_ctl("lw_c1", 4'b1100, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        #1 chk_ctl("lw_c2", 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("lw_sc", {28'd0, StallCycles}, 32'd1);
        @(negedge clk);

        // plain mul/div occupancy
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            MdStartE = (c <= 4);
            #1;
            chk_ctl($sformatf("md_c%0d", c), (c <= 3) ? 4'b1110 : 4'b0000,
                    (c <= 3) ? 4'b0010 : 4'b0000, c == 4, c >= 2 && c <= 4);
            @(negedge clk);
        end
        chk("md_sc", {28'd0, StallCycles}, 32'd3);

        // mul/div frozen by two dmem wait states
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            MdStartE = (c <= 6);
            MemReqM  = (c == 2 || c == 3);
            DmemReadyM = 1'b0;
            #1;
            if (c == 2 || c == 3)
                chk_ctl($sformatf("mdms_c%0d", c), 4'b1111, 4'b0001, 1'b0, 1'b1);
            else if (c <= 5)
                chk_ctl($sformatf("mdms_c%0d", c), 4'b1110, 4'b0010, 1'b0, c != 1);
            else
                chk_ctl($sformatf("mdms_c%0d", c), 4'b0000, 4'b0000, c == 6, c == 6);
            @(negedge clk);
        end
        chk("mdms_sc", {28'd0, StallCycles}, 32'd5);

        // PCSrcE during an mdStall is ignored, then honoured once the op completes
        do_reset();
        MdStartE = 1; PCSrcE = 1;
        #1 chk_ctl("pcmd_c1", 4'b1110, 4'b0010, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 chk_ctl("pcmd_c4", 4'b0000, 4'b1100, 1'b1, 1'b1);
        @(negedge clk);
        clear_inputs();

        // async reset while BUSY with cnt=1
        do_reset();
        MdStartE = 1;
        @(negedge clk); @(negedge clk);
        #1 chk("rmid_pre_busy", {31'd0, MdBusy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_ctl("rmid_in", 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("rmid_sc", {28'd0, StallCycles}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        MdStartE = 0;
        #1 chk_ctl("rmid_after", 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        MdStartE = 1;
        #1 chk_ctl("rmid_restart", 4'b1110, 4'b0010, 1'b0, 1'b0);
        @(negedge clk);

        // StallCycles saturation
        do_reset();
        MemReqM = 1; DmemReadyM = 0;
        repeat (SC_MAX) @(negedge clk);
        #1 chk("sat_reach", {28'd0, StallCycles}, SC_MAX);
        repeat (5) @(negedge clk);
        #1 chk("sat_hold", {28'd0, StallCycles}, SC_MAX);

        // randomized cycles against the occupancy model
        do_reset();
        md_on = 0; md_el = 0; exp_sc = 0;
        for (int n = 0; n < 400; n++) begin
            logic ms, lw, mds;
            logic [3:0] est, efl;
            logic edone;
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            LoadE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE = ($urandom_range(0, 3) == 0);
            MdStartE = ($urandom_range(0, 3) == 0);
            MemReqM = ($urandom_range(0, 2) == 0);
            DmemReadyM = 1'($urandom_range(0, 1));

            ms  = MemReqM && !DmemReadyM;
            lw  = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            mds = md_on ? (md_el < MDL - 1) : MdStartE;
            if (ms)          begin est = 4'b1111; efl = 4'b0001; end
            else if (mds)    begin est = 4'b1110; efl = 4'b0010; end
            else if (PCSrcE) begin est = 4'b0000; efl = 4'b1100; end
            else if (lw)     begin est = 4'b1100; efl = 4'b0100; end
            else             begin est = 4'b0000; efl = 4'b0000; end
            edone = md_on != 0 && md_el == MDL - 1 && !ms;

            #1;
            chk($sformatf("rnd%0d.fa", n), {30'd0, ForwardAE}, {30'd0, fwd(Rs1E)});
            chk($sformatf("rnd%0d.fb", n), {30'd0, ForwardBE}, {30'd0, fwd(Rs2E)});
            chk_ctl($sformatf("rnd%0d", n), est, efl, edone, md_on != 0);
            chk($sformatf("rnd%0d.sc", n), {28'd0, StallCycles}, exp_sc);

            if (est[3] && exp_sc < SC_MAX) exp_sc++;
            if (!ms) begin
                if (md_on != 0) begin
                    md_el++;
                    if (md_el == MDL) md_on = 0;
                end else if (MdStartE) begin
                    md_on = 1;
                    md_el = 1;
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
